// File: rtl/mult_8u_x_8s.sv
// ----------------------------------------------------------------------------
// mult_8u_x_8s
//   Pipelined 8-bit unsigned x 8-bit signed multiplier with a 16-bit signed
//   product. The block accepts one operand pair per clock. The product appears
//   on result three clocks later. There is no handshake.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst     in   1   synchronous, active-high reset; clears every stage
//   n1      in   8   multiplicand, unsigned 0..255
//   n2      in   8   multiplier, two's complement -128..127
//   result  out  16  n1*n2, two's complement, registered
// ----------------------------------------------------------------------------
module mult_8u_x_8s (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  n1,
    input  logic [7:0]  n2,
    output logic [15:0] result
);

    logic        [7:0]  n1_p0;
    logic signed [7:0]  n2_p0;
    logic signed [15:0] psum_lo_p1;
    logic signed [15:0] psum_hi_p1;
    logic signed [15:0] sum_p2;

    logic signed [15:0] psum_lo_c;
    logic signed [15:0] psum_hi_c;

    // One partial-product row: the zero-extended multiplicand shifted by the
    // row weight, gated by the multiplier bit. The MSB row carries weight
    // -2^7, so it is negated rather than added. This handles n2 = -128 exactly
    // without going through a magnitude.
    function automatic logic signed [15:0] pp_row(
        input logic [7:0] a,
        input logic       sel,
        input logic [2:0] sh,
        input logic       neg
    );
        logic signed [15:0] ext;
        ext = $signed({8'b0, a}) <<< sh;
        if (!sel) begin
            return 16'sd0;
        end
        return neg ? -ext : ext;
    endfunction

    // Two 4-row adder trees. Every intermediate fits in 16 signed bits, so
    // the truncation to 16 bits is exact.
    always_comb begin
        psum_lo_c = 16'sd0;
        psum_hi_c = 16'sd0;
        for (int i = 0; i < 4; i++) begin
            psum_lo_c = psum_lo_c + pp_row(n1_p0, n2_p0[i], 3'(i), 1'b0);
        end
        for (int i = 4; i < 8; i++) begin
            psum_hi_c = psum_hi_c + pp_row(n1_p0, n2_p0[i], 3'(i), (i == 7));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n1_p0      <= '0;
            n2_p0      <= '0;
            psum_lo_p1 <= '0;
            psum_hi_p1 <= '0;
            sum_p2     <= '0;
        end else begin
            // stage p0: capture operands
            n1_p0      <= n1;
            n2_p0      <= n2;
            // stage p1: partial sums of rows 0..3 and 4..7
            psum_lo_p1 <= psum_lo_c;
            psum_hi_p1 <= psum_hi_c;
            // stage p2: final add
            sum_p2     <= psum_lo_p1 + psum_hi_p1;
        end
    end

    assign result = sum_p2;

endmodule

// File: tb/tb_mult_8u_x_8s.sv
module tb_mult_8u_x_8s;

    logic        clk;
    logic        rst;
    logic [7:0]  n1;
    logic [7:0]  n2;
    logic [15:0] result;

    int total;
    int bad;

    // expected-value delay line: slot 0 = driven one negedge ago, slot 2 = due now
    logic [15:0] hist_exp [0:2];
    logic        hist_vld [0:2];
    string       hist_tag [0:2];

    mult_8u_x_8s dut (
        .clk    (clk),
        .rst    (rst),
        .n1     (n1),
        .n2     (n2),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // At each negedge: check the product that is due, then drive the next
    // operands (or reset) and record what they should produce three clocks later.
    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] e, input string tag);
        @(negedge clk);
        if (hist_vld[2]) chk(hist_tag[2], result, hist_exp[2]);
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                hist_exp[i] = 16'h0000;
                hist_vld[i] = 1'b1;
                hist_tag[i] = {tag, "_flush"};
            end
        end else begin
            hist_exp[2] = hist_exp[1]; hist_vld[2] = hist_vld[1]; hist_tag[2] = hist_tag[1];
            hist_exp[1] = hist_exp[0]; hist_vld[1] = hist_vld[0]; hist_tag[1] = hist_tag[0];
            hist_exp[0] = e;           hist_vld[0] = 1'b1;        hist_tag[0] = tag;
        end
        rst = r;
        n1  = a;
        n2  = b;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [15:0] re;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            hist_vld[i] = 1'b0;
            hist_exp[i] = 16'h0000;
            hist_tag[i] = "none";
        end
        rst = 1'b1;
        n1  = 8'h00;
        n2  = 8'h00;

        // reset state
        step(1'b1, 8'h12, 8'h34, 16'h0000, "reset0");
        step(1'b1, 8'h56, 8'h78, 16'h0000, "reset1");

        // directed vectors streamed back to back
        step(1'b0, 8'h55, 8'h55, 16'h1C39, "basic_55x55");
        step(1'b0, 8'hAA, 8'hAA, 16'hC6E4, "neg_AAxAA");
        step(1'b0, 8'hFF, 8'h80, 16'h8080, "maxneg_FFx80");
        step(1'b0, 8'hFF, 8'h81, 16'h817F, "ext_FFx81");
        step(1'b0, 8'hFF, 8'h7F, 16'h7E81, "ext_FFx7F");
        step(1'b0, 8'h55, 8'hFF, 16'hFFAB, "ext_55xFF");
        step(1'b0, 8'hFF, 8'h00, 16'h0000, "zero_FFx00");
        step(1'b0, 8'h00, 8'hFF, 16'h0000, "zero_00xFF");
        step(1'b0, 8'h00, 8'h7F, 16'h0000, "zero_00x7F");
        step(1'b0, 8'h01, 8'h80, 16'hFF80, "one_01x80");
        step(1'b0, 8'h80, 8'h01, 16'h0080, "one_80x01");

        // reset with products in flight: none of them may appear
        step(1'b0, 8'h55, 8'h55, 16'h1C39, "pre_rst_a");
        step(1'b0, 8'hFF, 8'h80, 16'h8080, "pre_rst_b");
        step(1'b0, 8'hFF, 8'h7F, 16'h7E81, "pre_rst_c");
        step(1'b1, 8'hAA, 8'hAA, 16'h0000, "midrst");
        step(1'b0, 8'h03, 8'hFD, 16'hFFF7, "post_rst_a");
        step(1'b0, 8'h10, 8'h10, 16'h0100, "post_rst_b");
        step(1'b0, 8'hC8, 8'h9C, 16'hB1E0, "post_rst_c");

        // random pairs
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            re = 16'($signed({8'b0, ra}) * $signed(rb));
            step(1'b0, ra, rb, re, "random");
        end

        // drain the pipeline
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 8'h00, 16'h0000, "drain");
        @(negedge clk);
        if (hist_vld[2]) chk(hist_tag[2], result, hist_exp[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
